csa_resolver: RTL and testbench



---
 rtl/csa_resolver_if.sv | 24 ++
 rtl/csa_resolver.sv | 150 +++++++++++++++
 tb/tb_csa_resolver.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/csa_resolver_if.sv
// Handshake bundle for csa_resolver: carry-save pair in, resolved word plus carry out.
interface csa_resolver_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] carry_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, sum_in, carry_in, out_ready,
    input  in_ready, out_valid, result, cout, busy
  );

  modport slave (
    input  in_valid, sum_in, carry_in, out_ready,
    output in_ready, out_valid, result, cout, busy
  );
endinterface

// File: rtl/csa_resolver.sv
// Chunked carry-propagate adder resolving a carry-save pair, CHUNK bits per clock.
// Optional unsigned saturation on overflow when CSA_RESOLVE_SAT_EN is defined.
module csa_resolver #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  csa_resolver_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] carry_reg;
  logic [WIDTH-1:0] result_reg;
  logic [WIDTH-1:0] result_next;
  logic [IDX_W-1:0] idx_reg;
  logic             cflag_reg;
  logic             cout_reg;

  logic             accept;
  logic             add_step;
  logic             last_step;
  logic             in_ready_comb;
  logic             out_valid_comb;
  logic             busy_comb;

  logic [CHUNK-1:0] sum_chunk   [NCHUNK];
  logic [CHUNK-1:0] carry_chunk [NCHUNK];
  logic [CHUNK:0]   chunk_add;

  // Slice the captured operands so the active chunk is a plain array select.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign sum_chunk[gi]   = sum_reg[gi*CHUNK +: CHUNK];
      assign carry_chunk[gi] = carry_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign chunk_add = {1'b0, sum_chunk[idx_reg]} + {1'b0, carry_chunk[idx_reg]}
                   + {{CHUNK{1'b0}}, cflag_reg};

  // Only the chunk selected by idx is rewritten; the rest hold their value.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_result
      assign result_next[gi*CHUNK +: CHUNK] =
        (add_step && (idx_reg == IDX_W'(gi))) ? chunk_add[CHUNK-1:0]
                                              : result_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    in_ready_comb  = 1'b0;
    out_valid_comb = 1'b0;
    busy_comb      = 1'b0;
    accept         = 1'b0;
    add_step       = 1'b0;
    last_step      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        in_ready_comb = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        busy_comb = 1'b1;
        add_step  = 1'b1;
        if (idx_reg == LAST_IDX) begin
          last_step  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        busy_comb      = 1'b1;
        out_valid_comb = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      carry_reg <= '0;
      idx_reg   <= '0;
      cflag_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      sum_reg   <= bus.sum_in;
      carry_reg <= bus.carry_in;
      idx_reg   <= '0;
      cflag_reg <= 1'b0;
    end else if (add_step) begin
      idx_reg   <= last_step ? '0 : idx_reg + 1'b1;
      cflag_reg <= chunk_add[CHUNK];
      if (last_step) begin
        cout_reg <= chunk_add[CHUNK];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg <= '0;
    end else begin
`ifdef CSA_RESOLVE_SAT_EN
      // Final chunk overflowed: clamp the whole word instead of wrapping.
      if (last_step && chunk_add[CHUNK]) begin
        result_reg <= '1;
      end else begin
        result_reg <= result_next;
      end
`else
      result_reg <= result_next;
`endif
    end
  end

  assign bus.in_ready  = in_ready_comb;
  assign bus.out_valid = out_valid_comb;
  assign bus.busy      = busy_comb;
  assign bus.result    = result_reg;
  assign bus.cout      = cout_reg;
endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver: cycle-level scoreboard plus directed literal checks.
`timescale 1ns/1ps
module tb_csa_resolver;
  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csa_resolver_if #(.WIDTH(WIDTH)) bus ();

  csa_resolver #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
  endtask

  // Reference: plain integer addition, clamped when the saturating build is selected.
  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
    logic [WIDTH:0] t;
    t = {1'b0, s} + {1'b0, c};
`ifdef CSA_RESOLVE_SAT_EN
    if (t[WIDTH]) t[WIDTH-1:0] = '1;
`endif
    return t;
  endfunction

  // Scoreboard: one outstanding operation, result due NCHUNK edges after its accept edge.
  bit             pending = 1'b0;
  int             acc_cyc = 0;
  logic [WIDTH:0] exp_q   = '0;
  int             accept_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 1'b0;
      chk("reset_state", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.cout, bus.result}),
          32'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}));
    end else if (pending) begin
      automatic bit exp_ov = (cyc - acc_cyc) >= NCHUNK;
      chk("busy_flags", 32'({bus.in_ready, bus.out_valid, bus.busy}),
          32'({1'b0, exp_ov, 1'b1}));
      if (exp_ov) begin
        chk("model_result", 32'({bus.cout, bus.result}), 32'(exp_q));
        if (bus.out_ready) pending = 1'b0;
      end
    end else begin
      chk("idle_flags", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'({1'b1, 1'b0, 1'b0}));
      if (bus.in_valid) begin
        pending = 1'b1;
        acc_cyc = cyc + 1;
        exp_q   = ref_add(bus.sum_in, bus.carry_in);
        accept_log.push_back(cyc + 1);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [15:0] s, input logic [15:0] c, input bit keep);
    bus.sum_in   = s;
    bus.carry_in = c;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.in_ready && rst_n) begin
        @(posedge clk);
        #2;
        if (!keep) bus.in_valid = 1'b0;
        last_acc = cyc;
        $display("accept sum=0x%04h carry=0x%04h at cycle %0d", s, c, cyc);
        return;
      end
    end
    timeout_fail("accept_wait");
  endtask

  task automatic wait_out(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = cyc - last_acc;
        $display("result=0x%04h cout=%0d latency=%0d", bus.result, bus.cout, lat);
        return;
      end
    end
    timeout_fail("out_valid_wait");
  endtask

  logic [15:0] rs [3];
  logic [15:0] rc [3];

  initial begin
    int lat;
    int n0;
    bus.in_valid  = 1'b0;
    bus.sum_in    = '0;
    bus.carry_in  = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // 1: carry out of chunk 1 into chunk 2, latency pinned
    send(16'h00FF, 16'h0001, 1'b0);
    wait_out(lat);
    chk("t1_latency", 32'(lat), 32'd4);
    chk("t1_result", 32'(bus.result), 32'h0100);
    chk("t1_cout", 32'(bus.cout), 32'd0);
    step();

    // 2: carry rippling through chunks 0..2
    send(16'h0FFF, 16'h0001, 1'b0);
    wait_out(lat);
    chk("t2_result", 32'(bus.result), 32'h1000);
    chk("t2_cout", 32'(bus.cout), 32'd0);
    step();

    // 3: full overflow
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_out(lat);
`ifdef CSA_RESOLVE_SAT_EN
    chk("t3_result", 32'(bus.result), 32'hFFFF);
`else
    chk("t3_result", 32'(bus.result), 32'h0000);
`endif
    chk("t3_cout", 32'(bus.cout), 32'd1);
    step();

    // 4: backpressure with a competing input held valid
    bus.out_ready = 1'b0;
    send(16'h1357, 16'h2468, 1'b0);
    wait_out(lat);
    bus.sum_in   = 16'hAAAA;
    bus.carry_in = 16'h5555;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_hold_result", 32'({bus.cout, bus.result}), 32'({1'b0, 16'h37BF}));
      chk("t4_in_ready", 32'(bus.in_ready), 32'd0);
    end
    step();
    bus.out_ready = 1'b1;
    send(16'hAAAA, 16'h5555, 1'b0);
    wait_out(lat);
    chk("t4_next_result", 32'({bus.cout, bus.result}), 32'({1'b0, 16'hFFFF}));
    step();

    // 5: reset two cycles into an operation
    send(16'h0F0F, 16'h0101, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_async_flags", 32'({bus.in_ready, bus.out_valid, bus.busy, bus.cout}), 32'h8);
    chk("t5_async_result", 32'(bus.result), 32'h0000);
    @(posedge clk);
    #2;
    step();
    rst_n = 1'b1;
    send(16'h1234, 16'h1111, 1'b0);
    wait_out(lat);
    chk("t5_result", 32'({bus.cout, bus.result}), 32'({1'b0, 16'h2345}));
    step();

    // 6: back-to-back with in_valid and out_ready held high
    for (int k = 0; k < 3; k++) begin
      rs[k] = 16'($urandom);
      rc[k] = 16'($urandom);
    end
    n0 = accept_log.size();
    for (int k = 0; k < 3; k++) send(rs[k], rc[k], 1'b1);
    bus.in_valid = 1'b0;
    wait_out(lat);
    step();
    chk("t6_accepts", 32'(accept_log.size() - n0), 32'd3);
    if (accept_log.size() >= n0 + 3) begin
      chk("t6_spacing_a", 32'(accept_log[n0+1] - accept_log[n0]), 32'd6);
      chk("t6_spacing_b", 32'(accept_log[n0+2] - accept_log[n0+1]), 32'd6);
    end
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
